// File: rtl/avalon_watch_monitor.sv
// rtl/avalon_watch_monitor.sv - Passive Avalon-MM watch-window monitor with counters and trace FIFO
//
// Purpose: observes one Avalon-MM master port without driving it, matches every
// accepted transfer against NUM_WINDOWS base/mask windows, keeps saturating
// per-window read/write counters and records matching writes and matching read
// completions (readdatavalid) into a show-ahead trace FIFO. Sticky flags report
// dropped trace entries and pipelined-read protocol violations.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   address .. readdatavalid observed bus signals (inputs only)
//   win_base/win_mask/win_enable  packed window configuration, window i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   clear                   synchronous clear of counters, FIFO and sticky flags
//   write_count/read_count  packed per-window saturating counters
//   trace_valid/trace_pop   FIFO head valid / consume head
//   trace_window .. trace_byteenable  FIFO head fields (zero when empty)
//   trace_overflow          sticky: a trace entry was dropped
//   protocol_error          sticky: protocol violation observed
module avalon_watch_monitor #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_WINDOWS     = 4,
  parameter int COUNT_WIDTH     = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [ADDR_WIDTH-1:0]                  address,
  input  logic [DATA_WIDTH/8-1:0]                byteenable,
  input  logic                                   read,
  input  logic                                   write,
  input  logic [DATA_WIDTH-1:0]                  writedata,
  input  logic [DATA_WIDTH-1:0]                  readdata,
  input  logic                                   waitrequest,
  input  logic                                   readdatavalid,
  input  logic [NUM_WINDOWS*ADDR_WIDTH-1:0]      win_base,
  input  logic [NUM_WINDOWS*ADDR_WIDTH-1:0]      win_mask,
  input  logic [NUM_WINDOWS-1:0]                 win_enable,
  input  logic                                   clear,
  output logic [NUM_WINDOWS*COUNT_WIDTH-1:0]     write_count,
  output logic [NUM_WINDOWS*COUNT_WIDTH-1:0]     read_count,
  output logic                                   trace_valid,
  input  logic                                   trace_pop,
  output logic [((NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1)-1:0] trace_window,
  output logic                                   trace_is_write,
  output logic [ADDR_WIDTH-1:0]                  trace_address,
  output logic [DATA_WIDTH-1:0]                  trace_data,
  output logic [DATA_WIDTH/8-1:0]                trace_byteenable,
  output logic                                   trace_overflow,
  output logic                                   protocol_error
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int WIN_W  = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int FI_W   = $clog2(FIFO_DEPTH);
  localparam int FP_W   = FI_W + 1;
  localparam int FC_W   = FI_W + 2;
  localparam int TI_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TP_W   = TI_W + 1;
  localparam int TSLOTS = 1 << TI_W;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------- accept / match
  logic acc_rd, acc_wr, rw_both;
  assign acc_rd  = read & ~write & ~waitrequest;
  assign acc_wr  = write & ~read & ~waitrequest;
  assign rw_both = read & write & ~waitrequest;

  logic [NUM_WINDOWS-1:0] match;
  logic [WIN_W-1:0]       hit_idx;
  logic                   any_match;

  always_comb begin
    match   = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      match[i] = win_enable[i] &
                 (((address ^ win_base[i*ADDR_WIDTH +: ADDR_WIDTH]) &
                   win_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
    end
    // Walk downwards so the lowest matching index wins.
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = WIN_W'(i);
    end
  end

  assign any_match = |match;

  // ---------------------------------------------------------------- pending-read tracker
  // Every accepted read is queued, matching or not, so completions stay in order.
  logic                  t_matched [TSLOTS];
  logic [WIN_W-1:0]      t_win     [TSLOTS];
  logic [ADDR_WIDTH-1:0] t_addr    [TSLOTS];
  logic [BE_W-1:0]       t_be      [TSLOTS];
  logic [TP_W-1:0]       t_wptr, t_rptr, t_occ;
  logic                  t_empty, t_full, t_pop, t_push, t_drop;

  assign t_occ   = t_wptr - t_rptr;
  assign t_empty = (t_occ == '0);
  assign t_full  = (t_occ == TP_W'(MAX_OUTSTANDING));
  assign t_pop   = readdatavalid & ~t_empty;
  // A completion in the same cycle frees the head slot for the new read.
  assign t_push  = acc_rd & (~t_full | t_pop);
  assign t_drop  = acc_rd & t_full & ~t_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t_wptr <= '0;
      t_rptr <= '0;
    end else begin
      if (t_push) t_wptr <= t_wptr + TP_W'(1);
      if (t_pop)  t_rptr <= t_rptr + TP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (t_push) begin
      t_matched[t_wptr[TI_W-1:0]] <= any_match;
      t_win[t_wptr[TI_W-1:0]]     <= hit_idx;
      t_addr[t_wptr[TI_W-1:0]]    <= address;
      t_be[t_wptr[TI_W-1:0]]      <= byteenable;
    end
  end

  logic                  t_head_matched;
  logic [WIN_W-1:0]      t_head_win;
  logic [ADDR_WIDTH-1:0] t_head_addr;
  logic [BE_W-1:0]       t_head_be;
  assign t_head_matched = t_matched[t_rptr[TI_W-1:0]];
  assign t_head_win     = t_win[t_rptr[TI_W-1:0]];
  assign t_head_addr    = t_addr[t_rptr[TI_W-1:0]];
  assign t_head_be      = t_be[t_rptr[TI_W-1:0]];

  // ---------------------------------------------------------------- trace FIFO
  logic [WIN_W-1:0]      f_win  [FIFO_DEPTH];
  logic                  f_wr   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
  logic [BE_W-1:0]       f_be   [FIFO_DEPTH];
  logic [FP_W-1:0]       f_wptr, f_rptr, f_occ;
  logic [FI_W-1:0]       f_widx1;
  logic [FC_W-1:0]       f_free;
  logic [1:0]            n_req;
  logic                  f_pop, comp_push, wr_push, push0, push1, drop_any;

  assign f_occ       = f_wptr - f_rptr;
  assign trace_valid = (f_occ != '0);
  assign f_pop       = trace_pop & trace_valid;
  assign comp_push   = t_pop & t_head_matched & ~clear;
  assign wr_push     = acc_wr & any_match & ~clear;
  assign f_free      = FC_W'(FIFO_DEPTH) - {1'b0, f_occ} + {{FP_W{1'b0}}, f_pop};
  assign n_req       = {1'b0, comp_push} + {1'b0, wr_push};
  // Slot 0 takes the completion when present, slot 1 is only ever the write,
  // so running out of room drops the write first.
  assign push0       = (n_req != 2'd0) & (f_free != '0);
  assign push1       = (n_req == 2'd2) & (f_free > FC_W'(1));
  assign drop_any    = (n_req != 2'd0) & ({{FI_W{1'b0}}, n_req} > f_free);
  assign f_widx1     = f_wptr[FI_W-1:0] + FI_W'(1);

  logic [WIN_W-1:0]      e0_win;
  logic                  e0_wr;
  logic [ADDR_WIDTH-1:0] e0_addr;
  logic [DATA_WIDTH-1:0] e0_data;
  logic [BE_W-1:0]       e0_be;
  assign e0_win  = comp_push ? t_head_win  : hit_idx;
  assign e0_wr   = ~comp_push;
  assign e0_addr = comp_push ? t_head_addr : address;
  assign e0_data = comp_push ? readdata    : writedata;
  assign e0_be   = comp_push ? t_head_be   : byteenable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_wptr <= '0;
      f_rptr <= '0;
    end else if (clear) begin
      f_wptr <= '0;
      f_rptr <= '0;
    end else begin
      f_rptr <= f_rptr + FP_W'(f_pop);
      f_wptr <= f_wptr + FP_W'(push0) + FP_W'(push1);
    end
  end

  always_ff @(posedge clock) begin
    if (push0) begin
      f_win[f_wptr[FI_W-1:0]]  <= e0_win;
      f_wr[f_wptr[FI_W-1:0]]   <= e0_wr;
      f_addr[f_wptr[FI_W-1:0]] <= e0_addr;
      f_data[f_wptr[FI_W-1:0]] <= e0_data;
      f_be[f_wptr[FI_W-1:0]]   <= e0_be;
    end
    if (push1) begin
      f_win[f_widx1]  <= hit_idx;
      f_wr[f_widx1]   <= 1'b1;
      f_addr[f_widx1] <= address;
      f_data[f_widx1] <= writedata;
      f_be[f_widx1]   <= byteenable;
    end
  end

  // Head fields read as zero when empty so they match the reset values.
  assign trace_window     = trace_valid ? f_win[f_rptr[FI_W-1:0]]  : '0;
  assign trace_is_write   = trace_valid ? f_wr[f_rptr[FI_W-1:0]]   : 1'b0;
  assign trace_address    = trace_valid ? f_addr[f_rptr[FI_W-1:0]] : '0;
  assign trace_data       = trace_valid ? f_data[f_rptr[FI_W-1:0]] : '0;
  assign trace_byteenable = trace_valid ? f_be[f_rptr[FI_W-1:0]]   : '0;

  // ---------------------------------------------------------------- counters and flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_count <= '0;
      read_count  <= '0;
    end else if (clear) begin
      write_count <= '0;
      read_count  <= '0;
    end else begin
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        if (acc_wr & match[i] & (write_count[i*COUNT_WIDTH +: COUNT_WIDTH] != CNT_MAX))
          write_count[i*COUNT_WIDTH +: COUNT_WIDTH] <=
            write_count[i*COUNT_WIDTH +: COUNT_WIDTH] + COUNT_WIDTH'(1);
        if (acc_rd & match[i] & (read_count[i*COUNT_WIDTH +: COUNT_WIDTH] != CNT_MAX))
          read_count[i*COUNT_WIDTH +: COUNT_WIDTH] <=
            read_count[i*COUNT_WIDTH +: COUNT_WIDTH] + COUNT_WIDTH'(1);
      end
    end
  end

  logic perr_set;
  assign perr_set = rw_both | t_drop | (readdatavalid & t_empty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_overflow <= 1'b0;
      protocol_error <= 1'b0;
    end else if (clear) begin
      trace_overflow <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (drop_any) trace_overflow <= 1'b1;
      if (perr_set) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_watch_monitor.sv
// tb/tb_avalon_watch_monitor.sv - Randomized and directed bench for avalon_watch_monitor
module tb_avalon_watch_monitor;
  localparam int AW = 16, DW = 32, NW = 4, CW = 16, FD = 8, MO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteenable = '0;
  logic          read = 1'b0, write = 1'b0;
  logic [DW-1:0] writedata = '0, readdata = '0;
  logic          waitrequest = 1'b0, readdatavalid = 1'b0;
  logic [NW*AW-1:0] win_base = '0, win_mask = '0;
  logic [NW-1:0] win_enable = '0;
  logic          clear = 1'b0;
  logic [NW*CW-1:0] write_count, read_count;
  logic          trace_valid;
  logic          trace_pop = 1'b0;
  logic [1:0]    trace_window;
  logic          trace_is_write;
  logic [AW-1:0] trace_address;
  logic [DW-1:0] trace_data;
  logic [3:0]    trace_byteenable;
  logic          trace_overflow, protocol_error;

  int n_tests = 0;
  int n_fail  = 0;

  avalon_watch_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WINDOWS(NW),
    .COUNT_WIDTH(CW), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clock(clock), .reset(reset),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid),
    .win_base(win_base), .win_mask(win_mask), .win_enable(win_enable), .clear(clear),
    .write_count(write_count), .read_count(read_count),
    .trace_valid(trace_valid), .trace_pop(trace_pop), .trace_window(trace_window),
    .trace_is_write(trace_is_write), .trace_address(trace_address),
    .trace_data(trace_data), .trace_byteenable(trace_byteenable),
    .trace_overflow(trace_overflow), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------- reference model
  typedef struct { int win; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] be; } ent_t;
  typedef struct { bit matched; int win; logic [AW-1:0] addr; logic [3:0] be; } pend_t;

  ent_t  m_fifo[$];
  pend_t m_pend[$];
  int    m_wcnt[NW];
  int    m_rcnt[NW];
  bit    m_ovf, m_perr;

  task automatic m_reset();
    m_fifo.delete();
    m_pend.delete();
    for (int i = 0; i < NW; i++) begin m_wcnt[i] = 0; m_rcnt[i] = 0; end
    m_ovf = 0;
    m_perr = 0;
  endtask

  task automatic m_push(input ent_t e);
    if (m_fifo.size() < FD) m_fifo.push_back(e);
    else m_ovf = 1;
  endtask

  // Applies the bus inputs currently driven to the model, as the next edge will.
  task automatic model_step();
    bit    ar, aw, err, any, have_h;
    bit    hit[NW];
    int    low;
    pend_t h, p;
    ent_t  e;
    if (!reset) begin m_reset(); return; end
    ar = read && !write && !waitrequest;
    aw = write && !read && !waitrequest;
    err = read && write && !waitrequest;
    any = 0; low = 0;
    for (int i = NW - 1; i >= 0; i--) begin
      hit[i] = win_enable[i] && (((address ^ win_base[i*AW +: AW]) & win_mask[i*AW +: AW]) == 0);
      if (hit[i]) begin any = 1; low = i; end
    end
    have_h = 0;
    if (readdatavalid) begin
      if (m_pend.size() > 0) begin h = m_pend.pop_front(); have_h = 1; end
      else err = 1;
    end
    if (ar) begin
      p.matched = any; p.win = low; p.addr = address; p.be = byteenable;
      if (m_pend.size() < MO) m_pend.push_back(p);
      else err = 1;
    end
    if (clear) begin
      m_fifo.delete();
      for (int i = 0; i < NW; i++) begin m_wcnt[i] = 0; m_rcnt[i] = 0; end
      m_ovf = 0;
      m_perr = 0;
    end else begin
      if (err) m_perr = 1;
      for (int i = 0; i < NW; i++) begin
        if (hit[i] && aw) m_wcnt[i] = (m_wcnt[i] < 65535) ? m_wcnt[i] + 1 : 65535;
        if (hit[i] && ar) m_rcnt[i] = (m_rcnt[i] < 65535) ? m_rcnt[i] + 1 : 65535;
      end
      if (trace_pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (have_h && h.matched) begin
        e.win = h.win; e.wr = 0; e.addr = h.addr; e.data = readdata; e.be = h.be;
        m_push(e);
      end
      if (aw && any) begin
        e.win = low; e.wr = 1; e.addr = address; e.data = writedata; e.be = byteenable;
        m_push(e);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    read = 0; write = 0; waitrequest = 0; readdatavalid = 0; trace_pop = 0; clear = 0;
  endtask

  task automatic set_win(input int i, input logic [AW-1:0] b, input logic [AW-1:0] m, input bit en);
    win_base[i*AW +: AW] = b;
    win_mask[i*AW +: AW] = m;
    win_enable[i] = en;
  endtask

  task automatic do_clear();
    idle();
    clear = 1;
    tick();
    clear = 0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 0;
    idle();
    repeat (3) tick();
    n_tests++; if (write_count !== '0) begin n_fail++; $display("FAIL reset_wcnt: got %h want 0", write_count); end
    n_tests++; if (read_count !== '0) begin n_fail++; $display("FAIL reset_rcnt: got %h want 0", read_count); end
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
    n_tests++; if ({trace_window, trace_is_write, trace_address, trace_data, trace_byteenable} !== '0) begin
      n_fail++; $display("FAIL reset_trace: got %h %b %h %h %h want 0", trace_window, trace_is_write, trace_address, trace_data, trace_byteenable); end
    n_tests++; if ({trace_overflow, protocol_error} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b%b want 00", trace_overflow, protocol_error); end
    reset = 1;
    tick();
  endtask

  task automatic test_write_basic();
    set_win(0, 16'h4000, 16'hFFFF, 1);
    for (int i = 1; i < NW; i++) set_win(i, 0, 0, 0);
    do_clear();
    write = 1; address = 16'h4000; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    tick();
    idle();
    n_tests++; if (write_count[CW-1:0] !== 16'd1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", write_count[CW-1:0]); end
    n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b want 1", trace_valid); end
    n_tests++; if ({trace_window, trace_is_write, trace_address, trace_data, trace_byteenable} !== {2'd0, 1'b1, 16'h4000, 32'hDEADBEEF, 4'hF}) begin
      n_fail++; $display("FAIL wr_entry: got %h %b %h %h %h want 0 1 4000 deadbeef f", trace_window, trace_is_write, trace_address, trace_data, trace_byteenable); end
    trace_pop = 1;
    tick();
    trace_pop = 0;
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL wr_pop: got %b want 0", trace_valid); end
  endtask

  task automatic test_read_assoc();
    do_clear();
    read = 1; address = 16'h4000; byteenable = 4'h3;
    tick();
    address = 16'h1234; byteenable = 4'hC;
    tick();
    read = 0; readdatavalid = 1; readdata = 32'h11;
    tick();
    readdata = 32'h22;
    tick();
    idle();
    tick();
    n_tests++; if (read_count[CW-1:0] !== 16'd1) begin n_fail++; $display("FAIL rd_count: got %0d want 1", read_count[CW-1:0]); end
    n_tests++; if ({trace_valid, trace_window, trace_is_write, trace_address, trace_data, trace_byteenable} !== {1'b1, 2'd0, 1'b0, 16'h4000, 32'h11, 4'h3}) begin
      n_fail++; $display("FAIL rd_entry: got %b %h %b %h %h %h want 1 0 0 4000 11 3", trace_valid, trace_window, trace_is_write, trace_address, trace_data, trace_byteenable); end
    trace_pop = 1;
    tick();
    trace_pop = 0;
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rd_single: got %b want 0", trace_valid); end
    n_tests++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL rd_perr: got %b want 0", protocol_error); end
  endtask

  task automatic test_waitrequest();
    do_clear();
    write = 1; waitrequest = 1; address = 16'h4000; writedata = 32'hCAFE0001; byteenable = 4'h1;
    repeat (3) tick();
    n_tests++; if ({write_count[CW-1:0], trace_valid} !== {16'd0, 1'b0}) begin
      n_fail++; $display("FAIL wait_held: got cnt %0d valid %b want 0 0", write_count[CW-1:0], trace_valid); end
    waitrequest = 0;
    tick();
    idle();
    tick();
    n_tests++; if (write_count[CW-1:0] !== 16'd1) begin n_fail++; $display("FAIL wait_count: got %0d want 1", write_count[CW-1:0]); end
    n_tests++; if (trace_data !== 32'hCAFE0001) begin n_fail++; $display("FAIL wait_data: got %h want cafe0001", trace_data); end
    trace_pop = 1;
    tick();
    trace_pop = 0;
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL wait_once: got %b want 0", trace_valid); end
  endtask

  task automatic test_overlap_saturate();
    set_win(0, 16'h0000, 16'h0000, 1);
    set_win(1, 16'h7777, 16'h0000, 1);
    do_clear();
    write = 1; address = 16'h9ABC; writedata = 32'h5; byteenable = 4'hF;
    tick();
    idle();
    n_tests++; if ({write_count[CW-1:0], write_count[CW +: CW]} !== {16'd1, 16'd1}) begin
      n_fail++; $display("FAIL ovl_counts: got %0d %0d want 1 1", write_count[CW-1:0], write_count[CW +: CW]); end
    n_tests++; if (trace_window !== 2'd0) begin n_fail++; $display("FAIL ovl_window: got %0d want 0", trace_window); end
    do_clear();
    write = 1;
    for (int i = 0; i < 65537; i++) tick();
    idle();
    n_tests++; if (write_count[2*CW-1:0] !== {2{16'hFFFF}}) begin
      n_fail++; $display("FAIL sat_count: got %h want ffffffff", write_count[2*CW-1:0]); end
    n_tests++; if (write_count[CW-1:0] !== 16'(m_wcnt[0])) begin
      n_fail++; $display("FAIL sat_model: got %h want %h", write_count[CW-1:0], 16'(m_wcnt[0])); end
    set_win(1, 0, 0, 0);
  endtask

  task automatic test_fifo_overflow();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      write = 1; address = AW'(i); writedata = 32'h100 + i; byteenable = 4'hF;
      tick();
    end
    idle();
    n_tests++; if (trace_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", trace_overflow); end
    for (int i = 0; i < FD; i++) begin
      n_tests++; if ({trace_valid, trace_data} !== {1'b1, 32'h100 + i}) begin
        n_fail++; $display("FAIL ovf_entry%0d: got %b %h want 1 %h", i, trace_valid, trace_data, 32'h100 + i); end
      trace_pop = 1;
      tick();
    end
    trace_pop = 0;
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", trace_valid); end
    write = 1; address = 16'h1; tick(); tick();
    idle();
    do_clear();
    n_tests++; if ({trace_valid, trace_overflow, protocol_error} !== 3'b000) begin
      n_fail++; $display("FAIL clear_state: got %b%b%b want 000", trace_valid, trace_overflow, protocol_error); end
  endtask

  task automatic test_back_to_back();
    set_win(0, 16'h4000, 16'hFFFF, 1);
    do_clear();
    readdatavalid = 1; readdata = 32'h99;
    tick();
    idle();
    n_tests++; if ({protocol_error, trace_valid} !== 2'b10) begin
      n_fail++; $display("FAIL orphan_rdv: got perr %b valid %b want 1 0", protocol_error, trace_valid); end
    do_clear();
    read = 1; write = 1; address = 16'h4000;
    tick();
    idle();
    n_tests++; if ({protocol_error, write_count[CW-1:0], read_count[CW-1:0]} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL rw_both: got perr %b w %0d r %0d want 1 0 0", protocol_error, write_count[CW-1:0], read_count[CW-1:0]); end
    do_clear();
    read = 1; address = 16'h4000; byteenable = 4'h1;
    tick();
    read = 0; readdatavalid = 1; readdata = 32'h55;
    write = 1; writedata = 32'h77; byteenable = 4'h2;
    tick();
    idle();
    n_tests++; if ({trace_is_write, trace_data, trace_byteenable} !== {1'b0, 32'h55, 4'h1}) begin
      n_fail++; $display("FAIL dual_first: got %b %h %h want 0 55 1", trace_is_write, trace_data, trace_byteenable); end
    trace_pop = 1;
    tick();
    trace_pop = 0;
    n_tests++; if ({trace_valid, trace_is_write, trace_data, trace_byteenable} !== {2'b11, 32'h77, 4'h2}) begin
      n_fail++; $display("FAIL dual_second: got %b %b %h %h want 1 1 77 2", trace_valid, trace_is_write, trace_data, trace_byteenable); end
    do_clear();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        for (int i = 0; i < NW; i++)
          set_win(i, AW'($urandom), AW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      end
      address     = AW'($urandom);
      byteenable  = 4'($urandom);
      writedata   = $urandom;
      readdata    = $urandom;
      read        = $urandom_range(0, 2) == 0;
      write       = $urandom_range(0, 2) == 0;
      waitrequest = $urandom_range(0, 3) == 0;
      readdatavalid = (m_pend.size() > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 40) == 0);
      trace_pop   = $urandom_range(0, 2) == 0;
      clear       = $urandom_range(0, 120) == 0;
      tick();
      n_tests++; if (trace_valid !== (m_fifo.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, trace_valid, m_fifo.size() > 0); end
      if (m_fifo.size() > 0) begin
        n_tests++;
        if ({trace_window, trace_is_write, trace_address, trace_data, trace_byteenable} !==
            {2'(m_fifo[0].win), m_fifo[0].wr, m_fifo[0].addr, m_fifo[0].data, m_fifo[0].be}) begin
          n_fail++;
          $display("FAIL rnd_head c%0d: got %h %b %h %h %h want %h %b %h %h %h", c, trace_window, trace_is_write,
                   trace_address, trace_data, trace_byteenable, 2'(m_fifo[0].win), m_fifo[0].wr,
                   m_fifo[0].addr, m_fifo[0].data, m_fifo[0].be);
        end
      end
      for (int i = 0; i < NW; i++) begin
        n_tests++; if ({write_count[i*CW +: CW], read_count[i*CW +: CW]} !== {16'(m_wcnt[i]), 16'(m_rcnt[i])}) begin
          n_fail++; $display("FAIL rnd_cnt%0d c%0d: got w %0d r %0d want w %0d r %0d", i, c,
                             write_count[i*CW +: CW], read_count[i*CW +: CW], m_wcnt[i], m_rcnt[i]); end
      end
      n_tests++; if ({trace_overflow, protocol_error} !== {m_ovf, m_perr}) begin
        n_fail++; $display("FAIL rnd_flags c%0d: got %b%b want %b%b", c, trace_overflow, protocol_error, m_ovf, m_perr); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    set_win(0, 0, 0, 1);
    write = 1; writedata = 32'hA5A5;
    repeat (3) tick();
    read = 1; write = 0;
    tick();
    #2;
    reset = 0;
    #1;
    n_tests++; if ({trace_valid, write_count, read_count, trace_data, protocol_error} !== '0) begin
      n_fail++; $display("FAIL async_reset: got valid %b w %h r %h data %h perr %b want all 0",
                         trace_valid, write_count, read_count, trace_data, protocol_error); end
    idle();
    m_reset();
    tick();
    reset = 1;
    readdatavalid = 1;
    tick();
    idle();
    n_tests++; if (protocol_error !== 1'b1) begin
      n_fail++; $display("FAIL async_tracker: got perr %b want 1 (tracker emptied)", protocol_error); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_write_basic();
    test_read_assoc();
    test_waitrequest();
    test_overlap_saturate();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
